// File: rtl/obb_phys_pkg.sv
// Shared types, constants and saturating arithmetic for the OBB body-state applier.
package obb_phys_pkg;

  localparam int unsigned POS_W   = 32;
  localparam int unsigned OMEGA_W = 11;
  localparam int unsigned ANGLE_W = 10;

  localparam logic signed [POS_W-1:0] OBB_GRAVITY = 32'sd64;

  typedef struct packed {
    logic signed [POS_W-1:0]   pos_x;
    logic signed [POS_W-1:0]   pos_y;
    logic signed [POS_W-1:0]   vel_x;
    logic signed [POS_W-1:0]   vel_y;
    logic signed [OMEGA_W-1:0] omega;
    logic [ANGLE_W-1:0]        angle;
  } body_state_t;

  typedef enum logic [1:0] {
    IDLE,
    APPLY_A,
    APPLY_B,
    INTEGRATE
  } applier_state_e;

  // a + b (or a - b when sub) clamped to the signed 32-bit range
  function automatic logic signed [31:0] sat_add32(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input logic               sub);
    logic signed [32:0] s;
    s = sub ? ({a[31], a} - {b[31], b}) : ({a[31], a} + {b[31], b});
    if (s[32] != s[31]) return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return s[31:0];
  endfunction

  // a + b (or a - b when sub) clamped to the signed 11-bit range
  function automatic logic signed [10:0] sat_add11(input logic signed [10:0] a,
                                                   input logic signed [10:0] b,
                                                   input logic               sub);
    logic signed [11:0] s;
    s = sub ? ({a[10], a} - {b[10], b}) : ({a[10], a} + {b[10], b});
    if (s[11] != s[10]) return s[11] ? 11'sh400 : 11'sh3FF;
    return s[10:0];
  endfunction

endpackage

// File: rtl/obb_body_integrator.sv
// One-frame integration of a single body: position from velocity, angle from omega.
// Define OBB_GRAVITY_EN to add a saturating gravity term to vel_y after the position step.
module obb_body_integrator
  import obb_phys_pkg::*;
#(
  parameter int unsigned VEL_SHIFT = 4
) (
  input  body_state_t body_i,
  output body_state_t body_o
);

  always_comb begin
    body_o       = body_i;
    body_o.pos_x = body_i.pos_x + (body_i.vel_x >>> VEL_SHIFT);
    body_o.pos_y = body_i.pos_y + (body_i.vel_y >>> VEL_SHIFT);
    body_o.angle = body_i.angle + body_i.omega[ANGLE_W-1:0];
`ifdef OBB_GRAVITY_EN
    body_o.vel_y = sat_add32(body_i.vel_y, OBB_GRAVITY, 1'b0);
`else
    body_o.vel_y = body_i.vel_y;
`endif
  end

endmodule

// File: rtl/obb_impulse_applier.sv
// Write-back end of the box-box resolver: applies contact impulses/nudges to a body
// register file and integrates all bodies once per frame (gravity via OBB_GRAVITY_EN).
module obb_impulse_applier
  import obb_phys_pkg::*;
#(
  parameter int unsigned NUM_BODIES = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_BODIES),
  parameter int unsigned VEL_SHIFT  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      contact_valid,
  output logic                      contact_ready,
  input  logic [IDX_W-1:0]          contact_a_idx,
  input  logic [IDX_W-1:0]          contact_b_idx,
  input  logic signed [31:0]        impulse_x,
  input  logic signed [31:0]        impulse_y,
  input  logic signed [31:0]        nudge_x,
  input  logic signed [31:0]        nudge_y,
  input  logic signed [10:0]        rotational_impulse,
  output logic                      contact_err,
  input  logic                      frame_start,
  output logic                      frame_done,
  input  logic                      body_wr_en,
  input  logic [IDX_W-1:0]          body_wr_idx,
  input  logic signed [31:0]        wr_pos_x,
  input  logic signed [31:0]        wr_pos_y,
  input  logic signed [31:0]        wr_vel_x,
  input  logic signed [31:0]        wr_vel_y,
  input  logic signed [10:0]        wr_omega,
  input  logic [IDX_W-1:0]          body_rd_idx,
  output logic signed [31:0]        rd_pos_x,
  output logic signed [31:0]        rd_pos_y,
  output logic signed [31:0]        rd_vel_x,
  output logic signed [31:0]        rd_vel_y,
  output logic signed [10:0]        rd_omega,
  output logic [9:0]                rd_angle
);

  applier_state_e      state_q;
  logic [IDX_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    a_idx_q;
  logic [IDX_W-1:0]    b_idx_q;
  logic signed [31:0]  imp_x_q;
  logic signed [31:0]  imp_y_q;
  logic signed [31:0]  nud_x_q;
  logic signed [31:0]  nud_y_q;
  logic signed [10:0]  rot_q;
  logic                pending_q;
  logic                contact_err_q;
  logic                frame_done_q;

  body_state_t         body_q [NUM_BODIES];
  body_state_t         body_d [NUM_BODIES];
  body_state_t         integ_body;
  body_state_t         rd_body;

  logic                contact_fire;
  logic                contact_bad;
  logic                last_body;

  assign contact_ready = (state_q == IDLE) && !body_wr_en;
  assign contact_fire  = contact_valid && contact_ready;
  assign contact_bad   = (contact_a_idx == contact_b_idx) ||
                         (32'(contact_a_idx) >= NUM_BODIES) ||
                         (32'(contact_b_idx) >= NUM_BODIES);
  assign last_body     = (cnt_q == IDX_W'(NUM_BODIES - 1));

  assign contact_err   = contact_err_q;
  assign frame_done    = frame_done_q;

  obb_body_integrator #(
    .VEL_SHIFT (VEL_SHIFT)
  ) u_integrator (
    .body_i (body_q[cnt_q]),
    .body_o (integ_body)
  );

  assign rd_body  = body_q[body_rd_idx];
  assign rd_pos_x = rd_body.pos_x;
  assign rd_pos_y = rd_body.pos_y;
  assign rd_vel_x = rd_body.vel_x;
  assign rd_vel_y = rd_body.vel_y;
  assign rd_omega = rd_body.omega;
  assign rd_angle = rd_body.angle;

  // Register-file next state: host write, contact halves, or one integrated body
  always_comb begin
    body_d = body_q;
    unique case (state_q)
      IDLE: begin
        if (body_wr_en) begin
          body_d[body_wr_idx].pos_x = wr_pos_x;
          body_d[body_wr_idx].pos_y = wr_pos_y;
          body_d[body_wr_idx].vel_x = wr_vel_x;
          body_d[body_wr_idx].vel_y = wr_vel_y;
          body_d[body_wr_idx].omega = wr_omega;
          body_d[body_wr_idx].angle = '0;
        end
      end
      APPLY_A: begin
        body_d[a_idx_q].vel_x = sat_add32(body_q[a_idx_q].vel_x, imp_x_q, 1'b0);
        body_d[a_idx_q].vel_y = sat_add32(body_q[a_idx_q].vel_y, imp_y_q, 1'b0);
        body_d[a_idx_q].pos_x = body_q[a_idx_q].pos_x + nud_x_q;
        body_d[a_idx_q].pos_y = body_q[a_idx_q].pos_y + nud_y_q;
        body_d[a_idx_q].omega = sat_add11(body_q[a_idx_q].omega, rot_q, 1'b0);
      end
      APPLY_B: begin
        body_d[b_idx_q].vel_x = sat_add32(body_q[b_idx_q].vel_x, imp_x_q, 1'b1);
        body_d[b_idx_q].vel_y = sat_add32(body_q[b_idx_q].vel_y, imp_y_q, 1'b1);
        body_d[b_idx_q].pos_x = body_q[b_idx_q].pos_x - nud_x_q;
        body_d[b_idx_q].pos_y = body_q[b_idx_q].pos_y - nud_y_q;
        body_d[b_idx_q].omega = sat_add11(body_q[b_idx_q].omega, rot_q, 1'b1);
      end
      INTEGRATE: begin
        body_d[cnt_q] = integ_body;
      end
      default: ;
    endcase
  end

  // Control FSM, contact latch and register file update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      a_idx_q       <= '0;
      b_idx_q       <= '0;
      imp_x_q       <= '0;
      imp_y_q       <= '0;
      nud_x_q       <= '0;
      nud_y_q       <= '0;
      rot_q         <= '0;
      pending_q     <= 1'b0;
      contact_err_q <= 1'b0;
      frame_done_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_BODIES; i++) body_q[i] <= '0;
    end else begin
      body_q        <= body_d;
      contact_err_q <= 1'b0;
      frame_done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (contact_fire) begin
            a_idx_q <= contact_a_idx;
            b_idx_q <= contact_b_idx;
            imp_x_q <= impulse_x;
            imp_y_q <= impulse_y;
            nud_x_q <= nudge_x;
            nud_y_q <= nudge_y;
            rot_q   <= rotational_impulse;
            if (contact_bad) contact_err_q <= 1'b1;
            else             state_q       <= APPLY_A;
            if (frame_start) pending_q <= 1'b1;
          end else if (frame_start || pending_q) begin
            cnt_q   <= '0;
            state_q <= INTEGRATE;
          end
        end
        APPLY_A: begin
          state_q <= APPLY_B;
          if (frame_start) pending_q <= 1'b1;
        end
        APPLY_B: begin
          state_q <= IDLE;
          if (frame_start) pending_q <= 1'b1;
        end
        INTEGRATE: begin
          // Pulses arriving mid-frame coalesce into the frame being run
          if (last_body) begin
            frame_done_q <= 1'b1;
            pending_q    <= 1'b0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obb_impulse_applier.sv
// Self-checking bench for obb_impulse_applier: contact vector table plus
// hand-written frame/reset sequences.
module tb_obb_impulse_applier;

  logic               clk = 1'b0;
  logic               reset;
  logic               contact_valid;
  logic               contact_ready;
  logic [1:0]         contact_a_idx;
  logic [1:0]         contact_b_idx;
  logic signed [31:0] impulse_x;
  logic signed [31:0] impulse_y;
  logic signed [31:0] nudge_x;
  logic signed [31:0] nudge_y;
  logic signed [10:0] rotational_impulse;
  logic               contact_err;
  logic               frame_start;
  logic               frame_done;
  logic               body_wr_en;
  logic [1:0]         body_wr_idx;
  logic signed [31:0] wr_pos_x;
  logic signed [31:0] wr_pos_y;
  logic signed [31:0] wr_vel_x;
  logic signed [31:0] wr_vel_y;
  logic signed [10:0] wr_omega;
  logic [1:0]         body_rd_idx;
  logic signed [31:0] rd_pos_x;
  logic signed [31:0] rd_pos_y;
  logic signed [31:0] rd_vel_x;
  logic signed [31:0] rd_vel_y;
  logic signed [10:0] rd_omega;
  logic [9:0]         rd_angle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obb_impulse_applier dut (
    .clk                (clk),
    .reset              (reset),
    .contact_valid      (contact_valid),
    .contact_ready      (contact_ready),
    .contact_a_idx      (contact_a_idx),
    .contact_b_idx      (contact_b_idx),
    .impulse_x          (impulse_x),
    .impulse_y          (impulse_y),
    .nudge_x            (nudge_x),
    .nudge_y            (nudge_y),
    .rotational_impulse (rotational_impulse),
    .contact_err        (contact_err),
    .frame_start        (frame_start),
    .frame_done         (frame_done),
    .body_wr_en         (body_wr_en),
    .body_wr_idx        (body_wr_idx),
    .wr_pos_x           (wr_pos_x),
    .wr_pos_y           (wr_pos_y),
    .wr_vel_x           (wr_vel_x),
    .wr_vel_y           (wr_vel_y),
    .wr_omega           (wr_omega),
    .body_rd_idx        (body_rd_idx),
    .rd_pos_x           (rd_pos_x),
    .rd_pos_y           (rd_pos_y),
    .rd_vel_x           (rd_vel_x),
    .rd_vel_y           (rd_vel_y),
    .rd_omega           (rd_omega),
    .rd_angle           (rd_angle)
  );

  typedef struct {
    logic [1:0]         a;
    logic [1:0]         b;
    logic signed [31:0] va;
    logic signed [31:0] vb;
    logic signed [10:0] oa;
    logic signed [10:0] ob;
    logic signed [31:0] ix;
    logic signed [31:0] iy;
    logic signed [31:0] nx;
    logic signed [31:0] ny;
    logic signed [10:0] rot;
    logic               err;
    logic signed [31:0] e_va;
    logic signed [31:0] e_vb;
    logic signed [31:0] e_pa;
    logic signed [31:0] e_pb;
    logic signed [31:0] e_vya;
    logic signed [31:0] e_vyb;
    logic signed [10:0] e_oa;
    logic signed [10:0] e_ob;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] idx, input logic signed [31:0] px,
                            input logic signed [31:0] py, input logic signed [31:0] vx,
                            input logic signed [31:0] vy, input logic signed [10:0] om);
    body_wr_en  = 1'b1;
    body_wr_idx = idx;
    wr_pos_x    = px;
    wr_pos_y    = py;
    wr_vel_x    = vx;
    wr_vel_y    = vy;
    wr_omega    = om;
    tick();
    body_wr_en  = 1'b0;
  endtask

  task automatic set_contact(input logic [1:0] a, input logic [1:0] b,
                             input logic signed [31:0] ix, input logic signed [31:0] iy,
                             input logic signed [31:0] nx, input logic signed [31:0] ny,
                             input logic signed [10:0] rot);
    contact_a_idx      = a;
    contact_b_idx      = b;
    impulse_x          = ix;
    impulse_y          = iy;
    nudge_x            = nx;
    nudge_y            = ny;
    rotational_impulse = rot;
    contact_valid      = 1'b1;
  endtask

  task automatic rd(input logic [1:0] idx);
    body_rd_idx = idx;
    #1;
  endtask

  task automatic chk_zero_body(input string tag, input logic [1:0] idx);
    rd(idx);
    chk($sformatf("%s_b%0d_pos_x", tag, idx), rd_pos_x, 0);
    chk($sformatf("%s_b%0d_pos_y", tag, idx), rd_pos_y, 0);
    chk($sformatf("%s_b%0d_vel_x", tag, idx), rd_vel_x, 0);
    chk($sformatf("%s_b%0d_vel_y", tag, idx), rd_vel_y, 0);
    chk($sformatf("%s_b%0d_omega", tag, idx), rd_omega, 0);
    chk($sformatf("%s_b%0d_angle", tag, idx), rd_angle, 0);
  endtask

  initial begin
    int done_cnt;

    // a, b, va, vb, oa, ob, ix, iy, nx, ny, rot, err, e_va, e_vb, e_pa, e_pb, e_vya, e_vyb, e_oa, e_ob
    vecs[0] = '{2'd0, 2'd1, 32'sd1000, 32'sd0, 11'sd0, 11'sd0,
                -32'sd500, 32'sd0, 32'sd8, 32'sd0, 11'sd3, 1'b0,
                32'sd500, 32'sd500, 32'sd8, -32'sd8, 32'sd0, 32'sd0, 11'sd3, -11'sd3};
    vecs[1] = '{2'd0, 2'd1, 32'sd2147483548, 32'sd0, 11'sd0, 11'sd0,
                32'sd1000, 32'sd0, 32'sd0, 32'sd0, 11'sd0, 1'b0,
                32'sh7FFF_FFFF, -32'sd1000, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 11'sd0, 11'sd0};
    vecs[2] = '{2'd0, 2'd1, 32'sd0, 32'sd0, 11'sd1020, 11'sd0,
                32'sd0, 32'sd0, 32'sd0, 32'sd0, 11'sd10, 1'b0,
                32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 11'sd1023, -11'sd10};
    vecs[3] = '{2'd2, 2'd3, -32'sd2147483600, 32'sd2147483600, 11'sd0, -11'sd1020,
                -32'sd100, 32'sd7, -32'sd5, 32'sd0, 11'sd10, 1'b0,
                32'sh8000_0000, 32'sh7FFF_FFFF, -32'sd5, 32'sd5, 32'sd7, -32'sd7, 11'sd10, 11'sh400};
    vecs[4] = '{2'd2, 2'd2, 32'sd11, 32'sd11, 11'sd5, 11'sd5,
                32'sd100, 32'sd0, 32'sd0, 32'sd0, 11'sd3, 1'b1,
                32'sd11, 32'sd11, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 11'sd5, 11'sd5};
    vecs[5] = '{2'd3, 2'd3, -32'sd7, -32'sd7, -11'sd1, -11'sd1,
                32'sd50, 32'sd1, 32'sd2, 32'sd3, -11'sd4, 1'b1,
                -32'sd7, -32'sd7, 32'sd0, 32'sd0, 32'sd0, 32'sd0, -11'sd1, -11'sd1};

    reset = 1'b1; contact_valid = 1'b0; frame_start = 1'b0; body_wr_en = 1'b0;
    contact_a_idx = '0; contact_b_idx = '0; impulse_x = '0; impulse_y = '0;
    nudge_x = '0; nudge_y = '0; rotational_impulse = '0; body_wr_idx = '0;
    wr_pos_x = '0; wr_pos_y = '0; wr_vel_x = '0; wr_vel_y = '0; wr_omega = '0;
    body_rd_idx = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    for (int i = 0; i < 4; i++) chk_zero_body("reset", 2'(i));
    chk("reset_ready", contact_ready, 1);
    chk("reset_err", contact_err, 0);
    chk("reset_done", frame_done, 0);

    // Host write blocks contacts and lands the next cycle
    body_wr_en = 1'b1; body_wr_idx = 2'd1; wr_vel_x = 32'sd77; wr_omega = 11'sd9;
    set_contact(2'd0, 2'd1, 32'sd5, 32'sd0, 32'sd0, 32'sd0, 11'sd0);
    #1;
    chk("wr_blocks_ready", contact_ready, 0);
    tick();
    body_wr_en = 1'b0; contact_valid = 1'b0;
    rd(2'd1);
    chk("wr_vel_x", rd_vel_x, 77);
    chk("wr_omega", rd_omega, 9);
    chk("wr_then_ready", contact_ready, 1);
    rd(2'd0);
    chk("wr_no_contact_b0", rd_vel_x, 0);

    // Contact vector table
    for (int i = 0; i < 6; i++) begin
      host_write(vecs[i].a, 32'sd0, 32'sd0, vecs[i].va, 32'sd0, vecs[i].oa);
      host_write(vecs[i].b, 32'sd0, 32'sd0, vecs[i].vb, 32'sd0, vecs[i].ob);
      set_contact(vecs[i].a, vecs[i].b, vecs[i].ix, vecs[i].iy, vecs[i].nx, vecs[i].ny,
                  vecs[i].rot);
      #1;
      chk($sformatf("v%0d_ready_pre", i), contact_ready, 1);
      tick();
      contact_valid = 1'b0;
      chk($sformatf("v%0d_err", i), contact_err, vecs[i].err);
      if (vecs[i].err) begin
        chk($sformatf("v%0d_ready_disc", i), contact_ready, 1);
        tick();
      end else begin
        chk($sformatf("v%0d_ready_c1", i), contact_ready, 0);
        tick();
        chk($sformatf("v%0d_ready_c2", i), contact_ready, 0);
        tick();
        chk($sformatf("v%0d_ready_c3", i), contact_ready, 1);
      end
      chk($sformatf("v%0d_err_clr", i), contact_err, 0);
      rd(vecs[i].a);
      chk($sformatf("v%0d_a_vel_x", i), rd_vel_x, vecs[i].e_va);
      chk($sformatf("v%0d_a_vel_y", i), rd_vel_y, vecs[i].e_vya);
      chk($sformatf("v%0d_a_pos_x", i), rd_pos_x, vecs[i].e_pa);
      chk($sformatf("v%0d_a_omega", i), rd_omega, vecs[i].e_oa);
      rd(vecs[i].b);
      chk($sformatf("v%0d_b_vel_x", i), rd_vel_x, vecs[i].e_vb);
      chk($sformatf("v%0d_b_vel_y", i), rd_vel_y, vecs[i].e_vyb);
      chk($sformatf("v%0d_b_pos_x", i), rd_pos_x, vecs[i].e_pb);
      chk($sformatf("v%0d_b_omega", i), rd_omega, vecs[i].e_ob);
    end

    // Frame integration and frame_done latency
    reset = 1'b1; tick(); reset = 1'b0;
    host_write(2'd3, 32'sd0, 32'sd0, 32'sd160, -32'sd32, 11'sd1);
    host_write(2'd0, 32'sd0, 32'sd0, -32'sd17, 32'sd0, 11'sd0);
    host_write(2'd1, 32'sd5, 32'sd0, 32'sd15, 32'sd0, 11'sd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("f1_ready_busy", contact_ready, 0);
    chk("f1_done_e0", frame_done, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("f1_done_e%0d", k), frame_done, 0);
    end
    tick();
    chk("f1_done_e4", frame_done, 1);
    chk("f1_ready_after", contact_ready, 1);
    tick();
    chk("f1_done_e5", frame_done, 0);
    rd(2'd3);
    chk("f1_b3_pos_x", rd_pos_x, 10);
    chk("f1_b3_pos_y", rd_pos_y, -2);
    chk("f1_b3_angle", rd_angle, 1);
`ifdef OBB_GRAVITY_EN
    chk("f1_b3_vel_y", rd_vel_y, 32);
`else
    chk("f1_b3_vel_y", rd_vel_y, -32);
`endif
    rd(2'd0);
    chk("f1_b0_pos_x", rd_pos_x, -2);
    rd(2'd1);
    chk("f1_b1_pos_x", rd_pos_x, 5);

    // Contact and frame_start together: contact first, then one frame
    set_contact(2'd3, 2'd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, -11'sd3);
    frame_start = 1'b1;
    #1;
    chk("cf_ready", contact_ready, 1);
    tick();
    contact_valid = 1'b0;
    frame_start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (frame_done) done_cnt++;
    end
    chk("cf_done_count", done_cnt, 1);
    rd(2'd3);
    chk("cf_b3_omega", rd_omega, -2);
    chk("cf_b3_angle", rd_angle, 1023);
    chk("cf_b3_pos_x", rd_pos_x, 20);
    chk("cf_b3_vel_x", rd_vel_x, 160);
`ifdef OBB_GRAVITY_EN
    chk("cf_b3_pos_y", rd_pos_y, 0);
`else
    chk("cf_b3_pos_y", rd_pos_y, -4);
`endif
    rd(2'd0);
    chk("cf_b0_omega", rd_omega, 3);
    chk("cf_b0_angle", rd_angle, 3);
    chk("cf_b0_pos_x", rd_pos_x, -4);

    // Reset during integration at counter=1 aborts cleanly
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) chk_zero_body("midrst", 2'(i));
    chk("midrst_ready", contact_ready, 1);
    chk("midrst_done", frame_done, 0);
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (frame_done) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_ready_idle", contact_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
